// File: rtl/mac_pkg.sv
// Shared widths and FSM encoding for the MAC stream controller.
package mac_pkg;

    localparam int unsigned A_W_DEF   = 8;
    localparam int unsigned B_W_DEF   = 8;
    localparam int unsigned ACC_W_DEF = 22;
    localparam int unsigned LEN_W_DEF = 7;
    localparam int unsigned MAX_LEN   = 64;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } state_e;

endpackage

// File: rtl/mac_mult_pipe.sv
// Two-stage multiply pipeline: operand registers, then product register, each with a valid bit.
module mac_mult_pipe #(
    parameter int unsigned A_W = 8,
    parameter int unsigned B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_in_valid,
    input  logic [A_W-1:0]     i_a,
    input  logic [B_W-1:0]     i_b,
    output logic               o_s1_valid,
    output logic               o_p_valid,
    output logic [A_W+B_W-1:0] o_prod
);

    logic               r_s1_valid;
    logic [A_W-1:0]     r_s1_a;
    logic [B_W-1:0]     r_s1_b;
    logic               r_p_valid;
    logic [A_W+B_W-1:0] r_prod;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_p_valid  <= 1'b0;
            r_prod     <= '0;
        end else begin
            r_s1_valid <= i_in_valid;
            if (i_in_valid) begin
                r_s1_a <= i_a;
                r_s1_b <= i_b;
            end
            r_p_valid <= r_s1_valid;
            r_prod    <= (A_W+B_W)'(r_s1_a) * (A_W+B_W)'(r_s1_b);
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_p_valid  = r_p_valid;
    assign o_prod     = r_prod;

endmodule

// File: rtl/mac_stream_ctrl.sv
// Job FSM, operand counter and next-state mux for an external accumulator register
// that has neither enable nor synchronous clear.
module mac_stream_ctrl
    import mac_pkg::*;
#(
    parameter int unsigned A_W   = A_W_DEF,
    parameter int unsigned B_W   = B_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    input  logic             i_op_valid,
    output logic             o_op_ready,
    input  logic [A_W-1:0]   i_a_data,
    input  logic [B_W-1:0]   i_b_data,
    input  logic [ACC_W-1:0] i_acc_q,
    output logic [ACC_W-1:0] o_acc_d,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [ACC_W-1:0] o_res_data,
    output logic             o_ovf
);

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    state_e             r_state, w_state_d;
    logic [LEN_W-1:0]   r_remaining, w_remaining_d;
    logic               r_ovf, w_ovf_d;
    logic               w_accept;
    logic               w_s1_valid;
    logic               w_p_valid;
    logic [A_W+B_W-1:0] w_prod;
    logic [ACC_W:0]     w_sum;

    mac_mult_pipe #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mult_pipe (
        .clk        (clk),
        .rst        (rst),
        .i_in_valid (w_accept),
        .i_a        (i_a_data),
        .i_b        (i_b_data),
        .o_s1_valid (w_s1_valid),
        .o_p_valid  (w_p_valid),
        .o_prod     (w_prod)
    );

    // Extra top bit captures the carry out of the accumulator width.
    assign w_sum = {1'b0, i_acc_q} + (ACC_W+1)'(w_prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_remaining <= w_remaining_d;
            r_ovf       <= w_ovf_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_remaining_d = r_remaining;
        w_ovf_d       = r_ovf;
        o_acc_d       = i_acc_q;
        o_op_ready    = 1'b0;
        o_res_valid   = 1'b0;
        w_accept      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (i_start && (i_len != '0) && (i_len <= MaxLen)) begin
                    w_remaining_d = i_len;
                    w_ovf_d       = 1'b0;
                    w_state_d     = StClear;
                end
            end
            StClear: begin
                o_acc_d   = '0;
                w_state_d = StRun;
            end
            StRun: begin
                o_op_ready = (r_remaining != '0);
                w_accept   = o_op_ready && i_op_valid;
                if (w_accept) begin
                    w_remaining_d = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // With stage 1 empty, any product in stage 2 lands in the register this edge.
                if (!w_s1_valid) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                o_res_valid = 1'b1;
                if (i_res_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if ((r_state == StRun || r_state == StDrain) && w_p_valid) begin
            o_acc_d = w_sum[ACC_W-1:0];
            w_ovf_d = r_ovf | w_sum[ACC_W];
        end
    end

    assign o_busy     = (r_state != StIdle);
    assign o_res_data = i_acc_q;
    assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_mac_stream_ctrl.sv
// Directed bench for mac_stream_ctrl with a behavioural accumulator register.
module tb_mac_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [6:0]  i_len = '0;
    logic        o_busy;
    logic        i_op_valid = 1'b0;
    logic        o_op_ready;
    logic [7:0]  i_a_data = '0;
    logic [7:0]  i_b_data = '0;
    logic [21:0] acc_q;
    logic [21:0] o_acc_d;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [21:0] o_res_data;
    logic        o_ovf;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= o_acc_d;
    end

    mac_stream_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .i_op_valid  (i_op_valid),
        .o_op_ready  (o_op_ready),
        .i_a_data    (i_a_data),
        .i_b_data    (i_b_data),
        .i_acc_q     (acc_q),
        .o_acc_d     (o_acc_d),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_ovf       (o_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        i_len   = 7'(len);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        t0      = cyc;
    endtask

    task automatic feed(input int a, input int b);
        logic rdy;
        i_op_valid = 1'b1;
        i_a_data   = 8'(a);
        i_b_data   = 8'(b);
        for (int k = 0; k < 100; k++) begin
            rdy = o_op_ready;
            step();
            if (rdy) begin
                i_op_valid = 1'b0;
                return;
            end
        end
        i_op_valid = 1'b0;
        n_tests++;
        n_fail++;
        $display("FAIL feed_timeout: op_ready never seen for pair (%0d,%0d)", a, b);
    endtask

    task automatic wait_res(output int lat);
        int k;
        k = 0;
        while (!o_res_valid && k < 300) begin
            step();
            k++;
        end
        lat = cyc - t0;
        if (!o_res_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL res_timeout: res_valid never rose");
        end
    endtask

    task automatic finish_res();
        i_res_ready = 1'b1;
        step();
        i_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_tests++;
        if ({o_busy, o_op_ready, o_res_valid, o_ovf} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {o_busy, o_op_ready, o_res_valid, o_ovf});
        end
        n_tests++;
        if (o_acc_d !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_acc_d: got %0d expected 0", o_acc_d);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_job(3);
        n_tests++;
        if (o_busy !== 1'b1 || o_acc_d !== 22'd0) begin
            n_fail++;
            $display("FAIL clear_cycle: busy=%b acc_d=%0d expected 1/0", o_busy, o_acc_d);
        end
        feed(2, 3);
        feed(4, 5);
        feed(10, 10);
        wait_res(lat);
        n_tests++;
        if (o_res_data !== 22'd126) begin
            n_fail++;
            $display("FAIL b2b_sum: got %0d expected 126", o_res_data);
        end
        n_tests++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d expected 6", lat);
        end
        n_tests++;
        if (o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_ovf: got %b expected 0", o_ovf);
        end
        finish_res();
    endtask

    task automatic test_max_len();
        int lat;
        start_job(64);
        for (int i = 0; i < 64; i++) feed(255, 255);
        wait_res(lat);
        n_tests++;
        if (o_res_data !== 22'd4161600) begin
            n_fail++;
            $display("FAIL max_sum: got %0d expected 4161600", o_res_data);
        end
        n_tests++;
        if (lat != 67) begin
            n_fail++;
            $display("FAIL max_latency: got %0d expected 67", lat);
        end
        n_tests++;
        if (o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL max_ovf: got %b expected 0", o_ovf);
        end
        finish_res();
    endtask

    task automatic test_gap();
        int lat;
        start_job(2);
        feed(7, 9);
        for (int g = 0; g < 3; g++) begin
            step();
            if (g >= 1) begin
                n_tests++;
                if (acc_q !== 22'd63) begin
                    n_fail++;
                    $display("FAIL gap_hold: got %0d expected 63 (gap cycle %0d)", acc_q, g);
                end
            end
        end
        feed(1, 1);
        wait_res(lat);
        n_tests++;
        if (o_res_data !== 22'd64 || lat != 8) begin
            n_fail++;
            $display("FAIL gap_result: got sum=%0d lat=%0d expected sum=64 lat=8",
                     o_res_data, lat);
        end
        finish_res();
    endtask

    task automatic test_result_hold();
        int lat;
        start_job(1);
        feed(3, 3);
        wait_res(lat);
        n_tests++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL hold_latency: got %0d expected 4", lat);
        end
        for (int i = 0; i < 5; i++) begin
            i_start = (i == 2);
            i_len   = 7'd1;
            step();
            n_tests++;
            if (o_res_valid !== 1'b1 || o_res_data !== 22'd9) begin
                n_fail++;
                $display("FAIL hold_stable: got valid=%b data=%0d expected 1/9 (cycle %0d)",
                         o_res_valid, o_res_data, i);
            end
        end
        i_start = 1'b0;
        finish_res();
        n_tests++;
        if (o_busy !== 1'b0 || o_res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: got busy=%b valid=%b expected 0/0",
                     o_busy, o_res_valid);
        end
        step();
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_start_ignored: got busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_abort();
        int lat;
        start_job(4);
        feed(5, 6);
        feed(7, 8);
        rst = 1'b1;
        #1;
        n_tests++;
        if ({o_op_ready, o_busy, o_res_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_flags: got %b expected 000",
                     {o_op_ready, o_busy, o_res_valid});
        end
        step();
        rst = 1'b0;
        step();
        start_job(1);
        feed(3, 3);
        wait_res(lat);
        n_tests++;
        if (o_res_data !== 22'd9 || lat != 4) begin
            n_fail++;
            $display("FAIL abort_rerun: got sum=%0d lat=%0d expected sum=9 lat=4",
                     o_res_data, lat);
        end
        finish_res();
    endtask

    task automatic test_bad_len();
        logic seen;
        seen = 1'b0;
        start_job(0);
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_busy: got %b expected 0", o_busy);
        end
        start_job(65);
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len65_busy: got %b expected 0", o_busy);
        end
        i_op_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            seen = seen | o_res_valid | o_op_ready | o_busy;
        end
        i_op_valid = 1'b0;
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_len_activity: got %b expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_max_len();
        test_gap();
        test_result_hold();
        test_abort();
        test_bad_len();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_stream_ctrl.md
Name: mac_stream_ctrl

Overview:
- Upstream control and datapath stage of the MAC system.
- Accepts a stream of N unsigned operand pairs over a valid/ready handshake and multiplies them in a 2-stage pipeline.
- Drives the next-state input of the external 22-bit accumulator register (acc_d) and reads that register's output back (acc_q).
- The accumulator register has no enable and no synchronous clear, so this block supplies hold, clear and add values every cycle, then presents the final sum on a result handshake.

Parameters:
- A_W, 8, operand A width (unsigned)
- B_W, 8, operand B width (unsigned)
- ACC_W, 22, accumulator width; must match the accumulator register
- LEN_W, 7, width of the length input; MAX_LEN = 64

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; shared with accumulator register
- start  in  1  begin job, sampled in IDLE only
- len  in  LEN_W  number of operand pairs, legal 1..64
- busy  out  1  high whenever state != IDLE
- op_valid  in  1  operand pair valid
- op_ready  out  1  operand pair accepted when op_valid&&op_ready
- a_data  in  A_W  operand A
- b_data  in  B_W  operand B
- acc_q  in  ACC_W  accumulator register output
- acc_d  out  ACC_W  accumulator register input (combinational)
- res_valid  out  1  final sum valid
- res_ready  in  1  consumer accepts result
- res_data  out  ACC_W  final sum (= acc_q in DONE)
- ovf  out  1  sticky: carry out of ACC_W during the job

Behaviour:
- Reset values: state IDLE, pipeline valids 0, remaining count 0, op_ready 0, res_valid 0, busy 0, ovf 0. acc_d = acc_q (hold); the register clears itself on the same rst.
- Reset mid-operation aborts the job. No res_valid is produced and no state survives into the next job.
- IDLE:
  - acc_d = acc_q.
  - start with 1<=len<=64: latch len into the remaining counter, clear ovf, go to CLEAR.
  - start with len==0 or len>64 is ignored; block stays IDLE.
- CLEAR: exactly 1 cycle. acc_d = 0, op_ready 0, then go to RUN.
- RUN:
  - op_ready = 1 while remaining > 0.
  - Each accept: register a_data/b_data into stage 1 (s1_valid), decrement remaining.
  - Acceptance of the last pair deasserts op_ready from the next cycle and moves to DRAIN.
- Pipeline, every cycle in RUN/DRAIN:
  - stage 2: prod_q <= s1_a*s1_b (A_W+B_W bits), p_valid <= s1_valid.
  - p_valid ? acc_d = acc_q + zero_ext(prod_q) : acc_d = acc_q.
  - Carry out of the ACC_W add sets ovf.
  - Back-to-back adds need no forwarding: acc_q is always exactly the previous cycle's acc_d.
- DRAIN: wait until s1_valid==0 && p_valid==0 at a clock edge, i.e. the last add has been captured by the register, then go to DONE.
- DONE:
  - res_valid = 1, res_data = acc_q, acc_d = acc_q.
  - Both outputs are held stable until res_ready; when res_valid&&res_ready, go to IDLE.
- Latency:
  - With start sampled at edge e0 and op_valid continuously high, pairs are accepted at e2..e(N+1).
  - res_valid rises at e(N+3), i.e. N+3 cycles after start.
  - op_valid gaps add one cycle each; the accumulator holds during bubbles.
- start while busy is ignored. op_valid outside RUN is ignored.
- Width: 64 x 255 x 255 = 4,161,600 < 2^22, so ovf never sets at default parameters. ovf exists for reparameterised builds; the sum wraps modulo 2^ACC_W.

Decomposition:
- Shared package mac_pkg:
  - default widths A_W, B_W, ACC_W, LEN_W
  - MAX_LEN = 64
  - FSM state encoding IDLE/CLEAR/RUN/DRAIN/DONE (3-bit)
- One sub-module, mac_mult_pipe:
  - 2-stage operand-register and product-register pipeline with valid bits, cleared by rst.
  - The FSM, counter and acc_d mux stay in the top module.

Test Plan:
- len=3; pairs (2,3),(4,5),(10,10) back-to-back -> res_data=126, res_valid at start+6 cycles, ovf=0.
- len=64; all pairs (255,255) continuous -> res_data=4,161,600, ovf=0, res_valid at start+67.
- len=2; (7,9), 3 idle cycles, (1,1) -> acc_q holds 63 through the gap; res_data=64 at start+8.
- len=1 (3,3); hold res_ready=0 for 5 cycles and pulse start meanwhile -> res_valid/res_data=9 stable, start ignored; res_ready=1 -> IDLE, busy=0 next cycle.
- len=4; assert rst after 2 accepts -> op_ready, busy, res_valid all 0 immediately; new job len=1 (3,3) -> res_data=9 with no residue.
- start with len=0, then len=65 -> busy stays 0, op_ready 0, no res_valid.
